// File: rtl/mdu_sched.sv
// Multi-cycle multiply/divide sequencer for the E stage.
// Holds HI/LO, models the fixed MDU latency with a busy counter, and raises
// a stall to the hazard unit while a later MDU instruction has to wait.
module mdu_sched #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        e_mdu,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mf_data
);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  localparam logic [3:0] MUL_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N = 4'(DIV_CYCLES);

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] hi_p, lo_p;
  logic        accept;

  logic [63:0]        prod_s, prod_u;
  logic signed [31:0] sa, sd, quo_s, rem_s;
  logic [31:0]        ud, quo_u, rem_u;

  assign accept  = e_mdu & ~busy;
  assign stall   = e_mdu & busy;
  assign mf_data = (op == 3'd7) ? hi : lo;

  // Arithmetic datapath. Divisor is forced to 1 for b==0 (result discarded)
  // and for INT_MIN / -1, where x/1 yields exactly the required 0x80000000 r0.
  always_comb begin
    prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    prod_u = {32'd0, a} * {32'd0, b};
    sa     = $signed(a);
    sd     = $signed(b);
    if (b == 32'd0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF))
      sd = 32'sd1;
    quo_s  = sa / sd;
    rem_s  = sa % sd;
    ud     = (b == 32'd0) ? 32'd1 : b;
    quo_u  = a / ud;
    rem_u  = a % ud;
  end

  // Sequencer FSM: start/complete multi-cycle ops, mt writes, HI/LO commit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      hi_p  <= '0;
      lo_p  <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          case (op)
            3'd0, 3'd1: begin
              {hi_p, lo_p} <= (op == 3'd0) ? prod_s : prod_u;
              cnt   <= MUL_N;
              busy  <= 1'b1;
              state <= MUL;
            end
            3'd2, 3'd3: begin
              if (b == 32'd0) begin
                hi_p <= hi;
                lo_p <= lo;
              end else if (op == 3'd2) begin
                hi_p <= rem_s;
                lo_p <= quo_s;
              end else begin
                hi_p <= rem_u;
                lo_p <= quo_u;
              end
              cnt   <= DIV_N;
              busy  <= 1'b1;
              state <= DIV;
            end
            3'd4:    lo <= a;
            3'd5:    hi <= a;
            default: ;
          endcase
        end
        MUL, DIV: begin
          if (cnt == 4'd1) begin
            hi    <= hi_p;
            lo    <= lo_p;
            cnt   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
